data_memory_ctrl: RTL and testbench

//   Parametrised CPU-to-data-memory controller; next generation of the combinational data memory bridge.

---
 rtl/data_memory_ctrl.sv | 176 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   CPU-to-data-memory controller. Accepts byte/half/word loads and stores on a
//   byte address and issues one word-addressed, byte-lane-enabled memory access.
//   Load data is lane-aligned and zero- or sign-extended. The memory may take any
//   number of cycles to answer with mem_ack. An access times out after TIMEOUT
//   cycles without an ack (TIMEOUT=0 waits forever).
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   addr                  CPU byte address
//   read_en, write_en     load / store request, sampled while busy=0
//   size                  0=byte 1=half 2=word 3=illegal
//   sign_ext              sign-extend (1) or zero-extend (0) load data
//   data_write            right-justified store data
//   data_read             last successful load result
//   busy, done, error     access in progress / completion pulse / error qualifier
//   mem_addr              memory word address
//   mem_read_en           read strobe, held until mem_ack
//   mem_write_en          write strobe, held until mem_ack
//   mem_byte_en           byte lane enables
//   mem_write_val         lane-shifted store data
//   mem_read_val, mem_ack memory read data and completion
module data_memory_ctrl #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 256,
    parameter int TIMEOUT   = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(MEM_SIZE*MEM_WIDTH/8)-1:0] addr,
    input  logic                                   read_en,
    input  logic                                   write_en,
    input  logic [1:0]                             size,
    input  logic                                   sign_ext,
    input  logic [MEM_WIDTH-1:0]                   data_write,
    output logic [MEM_WIDTH-1:0]                   data_read,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [$clog2(MEM_SIZE)-1:0]            mem_addr,
    output logic                                   mem_read_en,
    output logic                                   mem_write_en,
    output logic [MEM_WIDTH/8-1:0]                 mem_byte_en,
    output logic [MEM_WIDTH-1:0]                   mem_write_val,
    input  logic [MEM_WIDTH-1:0]                   mem_read_val,
    input  logic                                   mem_ack
);

    localparam int NB      = MEM_WIDTH / 8;
    localparam int OFF_W   = $clog2(NB);
    localparam int ADDR_W  = $clog2(MEM_SIZE * NB);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [OFF_W-1:0] lat_off;
    logic [OFF_W:0]   lat_bytes;
    logic             lat_sign;

    // Request decode
    logic [OFF_W:0]       req_bytes;
    logic [OFF_W-1:0]     req_off;
    logic                 req_err;
    logic [NB-1:0]        req_be;
    logic [MEM_WIDTH-1:0] req_mask;
    logic [MEM_WIDTH-1:0] req_wval;

    always_comb begin
        req_bytes = '0;
        case (size)
            2'd0:    req_bytes = (OFF_W+1)'(1);
            2'd1:    req_bytes = (OFF_W+1)'(2);
            2'd2:    req_bytes = (OFF_W+1)'(NB);
            default: req_bytes = '0;
        endcase
        req_off  = addr[OFF_W-1:0];
        req_err  = (read_en && write_en) || (size == 2'd3)
                 || (size == 2'd1 && addr[0])
                 || (size == 2'd2 && addr[OFF_W-1:0] != '0);
        // Shifting all-ones by the full width yields zero, so the full-word
        // case naturally produces an all-ones mask.
        req_be   = (~({NB{1'b1}} << req_bytes)) << req_off;
        req_mask = ~({MEM_WIDTH{1'b1}} << {req_bytes, 3'b000});
        req_wval = (data_write & req_mask) << {req_off, 3'b000};
    end

    // Load data alignment and extension
    logic [MEM_WIDTH-1:0] rd_shift;
    logic [MEM_WIDTH-1:0] rd_mask;
    logic [OFF_W+3:0]     rd_nbits_m1;
    logic                 rd_msb;
    logic [MEM_WIDTH-1:0] load_val;

    always_comb begin
        rd_shift    = mem_read_val >> {lat_off, 3'b000};
        rd_mask     = ~({MEM_WIDTH{1'b1}} << {lat_bytes, 3'b000});
        rd_nbits_m1 = {lat_bytes, 3'b000} - (OFF_W+4)'(1);
        rd_msb      = rd_shift[rd_nbits_m1[OFF_W+2:0]];
        load_val    = rd_shift & rd_mask;
        if (lat_sign && rd_msb) begin
            load_val = load_val | ~rd_mask;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lat_off       <= '0;
            lat_bytes     <= '0;
            lat_sign      <= 1'b0;
            data_read     <= '0;
            error         <= 1'b0;
            mem_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_byte_en   <= '0;
            mem_write_val <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (read_en || write_en) begin
                        lat_off   <= req_off;
                        lat_bytes <= req_bytes;
                        lat_sign  <= sign_ext;
                        error     <= req_err;
                        cnt       <= '0;
                        if (req_err) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_ACCESS;
                            mem_addr      <= addr[ADDR_W-1:OFF_W];
                            mem_read_en   <= read_en;
                            mem_write_en  <= write_en;
                            mem_byte_en   <= write_en ? req_be : '1;
                            mem_write_val <= write_en ? req_wval : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        if (mem_read_en) begin
                            data_read <= load_val;
                        end
                        state <= S_DONE;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        error        <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    error <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
//   Self-checking bench for data_memory_ctrl (default parameters). A byte-array
//   memory model answers the controller's strobes and predicts lane enables,
//   store data, load results, timeouts and error completions.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  addr;
    logic        read_en, write_en;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        busy, done, error;
    logic [7:0]  mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_write_val;
    logic [31:0] mem_read_val;
    logic        mem_ack;

    data_memory_ctrl #(.MEM_WIDTH(32), .MEM_SIZE(256), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .addr(addr), .read_en(read_en),
        .write_en(write_en), .size(size), .sign_ext(sign_ext),
        .data_write(data_write), .data_read(data_read), .busy(busy),
        .done(done), .error(error), .mem_addr(mem_addr),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_byte_en(mem_byte_en), .mem_write_val(mem_write_val),
        .mem_read_val(mem_read_val), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_b [0:1023];
    logic [31:0] exp_dr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mem_b[w*4+3], mem_b[w*4+2], mem_b[w*4+1], mem_b[w*4]};
    endfunction

    // One complete request. ack_dly = strobe cycle index on which mem_ack is
    // driven (0 = same cycle the strobe first appears); >=16 never acks.
    task automatic access(input bit rd, input bit wr, input logic [9:0] a,
                          input logic [1:0] sz, input bit sx,
                          input logic [31:0] wd, input int ack_dly);
        int n, off, cyc;
        bit err, acked;
        logic [31:0] exp_be, exp_wv, ld;
        n   = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
        off = int'(a) % 4;
        err = (rd && wr) || (n == 0);
        if (!err) err = (int'(a) % n) != 0;

        read_en = rd; write_en = wr; addr = a; size = sz;
        sign_ext = sx; data_write = wd;
        @(posedge clk); #1;
        read_en = 1'b0; write_en = 1'b0;
        addr = 10'($urandom); data_write = $urandom; sign_ext = 1'($urandom);
        check("busy_after_req", busy, 1);

        if (err) begin
            check("err_no_strobe", {mem_read_en, mem_write_en}, 0);
            check("err_done", done, 1);
            check("err_error", error, 1);
            check("err_data_read", data_read, exp_dr);
        end else begin
            exp_be = 32'hF;
            exp_wv = 0;
            if (wr) begin
                exp_be = ((32'd1 << n) - 1) << off;
                for (int i = 0; i < n; i++)
                    exp_wv = exp_wv | (((wd >> (8*i)) & 32'hFF) << (8*(off+i)));
            end
            acked = 1'b0;
            cyc   = 0;
            while (!acked && cyc < 16) begin
                check("strobe_rd", mem_read_en, rd);
                check("strobe_wr", mem_write_en, wr);
                check("done_low_in_access", done, 0);
                if (cyc == 0) begin
                    check("mem_addr", mem_addr, a / 4);
                    check("byte_en", mem_byte_en, exp_be);
                    if (wr) check("write_val", mem_write_val, exp_wv);
                end
                if (cyc == ack_dly) begin
                    mem_ack = 1'b1;
                    mem_read_val = model_word(int'(a) / 4);
                end else begin
                    mem_ack = 1'b0;
                    mem_read_val = $urandom;
                end
                read_en = 1'($urandom);   // must be ignored while busy
                @(posedge clk); #1;
                acked = mem_ack;
                mem_ack = 1'b0; read_en = 1'b0;
                cyc++;
            end
            check("strobe_dropped", {mem_read_en, mem_write_en}, 0);
            check("done_pulse", done, 1);
            check("error_flag", error, {31'd0, !acked});
            if (acked && wr)
                for (int i = 0; i < n; i++) mem_b[int'(a)+i] = wd[8*i +: 8];
            if (acked && rd) begin
                ld = 0;
                for (int i = 0; i < n; i++) ld = ld | (32'(mem_b[int'(a)+i]) << (8*i));
                if (sx && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8*n));
                exp_dr = ld;
            end
            check("data_read", data_read, exp_dr);
        end
        mem_ack = 1'($urandom);   // ack outside ACCESS must be ignored
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("done_cleared", done, 0);
        check("busy_cleared", busy, 0);
        check("error_cleared", error, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dly;
        bit rd, wr;
        logic [1:0] sz;
        logic [9:0] a;
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
        reset = 1'b1; read_en = 0; write_en = 0; addr = 0; size = 0;
        sign_ext = 0; data_write = 0; mem_read_val = 0; mem_ack = 0;
        exp_dr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_data_read", data_read, 0);
        check("rst_flags", {busy, done, error, mem_read_en, mem_write_en}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_byte_en", mem_byte_en, 0);
        check("rst_write_val", mem_write_val, 0);

        // Directed cases
        access(0, 1, 10'h008, 2'd2, 0, 32'hDEADBEEF, 2);
        access(0, 1, 10'h005, 2'd0, 0, 32'h000000AB, 0);
        mem_b[4] = 8'h00; mem_b[5] = 8'h00; mem_b[6] = 8'h12; mem_b[7] = 8'h80;
        access(1, 0, 10'h006, 2'd1, 1, 32'h0, 1);
        check("half_sext_value", exp_dr, 32'hFFFF8012);
        access(1, 0, 10'h006, 2'd1, 0, 32'h0, 0);
        check("half_zext_value", exp_dr, 32'h00008012);
        access(1, 0, 10'h003, 2'd2, 0, 32'h0, 0);
        access(1, 0, 10'h040, 2'd3, 0, 32'h0, 0);
        access(1, 1, 10'h040, 2'd2, 0, 32'h0, 0);
        access(1, 0, 10'h008, 2'd2, 0, 32'h0, 100);   // timeout
        access(1, 0, 10'h008, 2'd2, 0, 32'h0, 15);    // ack on last allowed cycle

        // Reset in the middle of an access
        read_en = 1; addr = 10'h010; size = 2'd2;
        @(posedge clk); #1;
        read_en = 0;
        @(posedge clk); #1;
        check("pre_reset_strobe", mem_read_en, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dr = 0;
        check("midrst_flags", {busy, done, error, mem_read_en, mem_write_en}, 0);
        check("midrst_data_read", data_read, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_byte_en", mem_byte_en, 0);
        access(1, 0, 10'h010, 2'd2, 0, 32'h0, 1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 19) == 0) begin rd = 1; wr = 1; end
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            a  = 10'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~10'(n - 1);
            case ($urandom_range(0, 9))
                0:       dly = 15;
                1:       dly = 20;
                default: dly = $urandom_range(0, 3);
            endcase
            access(rd, wr, a, sz, 1'($urandom), $urandom, dly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
